// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and sizes for the 8-way round-robin mux-select arbiter.
//   NUM_REQ     : number of requesters sharing the 8:1 mux
//   SEL_W       : width of the mux select / requester index
//   sel_t       : requester index type
//   arb_state_t : arbiter FSM state
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Purely combinational rotating-priority picker. Scans req starting at ptr
// and wrapping modulo 8; the first set bit wins.
// Ports:
//   req_i[7:0]     : request vector
//   ptr_i[2:0]     : highest-priority index for this scan
//   found_o        : at least one request is set
//   win_idx_o[2:0] : index of the winning requester (0 when found_o=0)
// -----------------------------------------------------------------------------
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  sel_t               ptr_i,
    output logic               found_o,
    output sel_t               win_idx_o
);

    sel_t idx;

    // Walk offsets from furthest to nearest so the nearest requester (lowest
    // offset from ptr) is the last write and therefore the winner.
    always_comb begin
        found_o   = 1'b0;
        win_idx_o = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + sel_t'(k);   // 3-bit add wraps mod 8
            if (req_i[idx]) begin
                found_o   = 1'b1;
                win_idx_o = idx;
            end
        end
    end

endmodule : rr_pick8

// File: rtl/mux_sel_arbiter8.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter8
// Round-robin arbiter driving the registered select of a shared 8:1 mux.
// One requester wins per arbitration; the pointer moves to winner+1 so the
// last winner has the lowest priority on the next scan.
//
// Optional feature (macro ARB_HOLD_EN): a winner keeps the grant while its
// request stays high, for at most MAX_HOLD consecutive cycles. Without the
// macro every grant lasts one cycle and arbitration runs every cycle.
//
// Parameters:
//   MAX_HOLD     : max consecutive grant cycles in hold mode (1..15)
// Ports:
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset
//   req_i[7:0]   : request vector
//   gnt_o[7:0]   : registered one-hot grant, zero when idle
//   sel_o[2:0]   : registered mux select, holds last value while idle
//   valid_o      : registered, high when gnt_o is non-zero
// -----------------------------------------------------------------------------
module mux_sel_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
        $error("mux_sel_arbiter8: MAX_HOLD must be in 1..15");
    end

    arb_state_t         state_q;
    sel_t               ptr_q;
    sel_t               sel_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               valid_q;

    logic               found;
    sel_t               win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               keep;

    rr_pick8 u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .found_o   (found),
        .win_idx_o (win_idx)
    );

    assign win_onehot = NUM_REQ'(1) << win_idx;

`ifdef ARB_HOLD_EN
    logic [3:0] hold_cnt_q;

    // Holder keeps the mux while still requesting and under its burst limit.
    assign keep = (state_q == GRANT) && req_i[sel_q] && (hold_cnt_q < 4'(MAX_HOLD));
`else
    assign keep = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
`ifdef ARB_HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else if (keep) begin
            // Continue the current burst: grant, select and pointer unchanged.
`ifdef ARB_HOLD_EN
            hold_cnt_q <= hold_cnt_q + 4'd1;
`endif
        end else if (found) begin
            // IDLE start or GRANT re-arbitration: identical handling, so a
            // handoff between requesters needs no idle bubble. Because ptr
            // already points past the holder, it can only re-win when alone.
            state_q    <= GRANT;
            ptr_q      <= win_idx + sel_t'(1);
            sel_q      <= win_idx;
            gnt_q      <= win_onehot;
            valid_q    <= 1'b1;
`ifdef ARB_HOLD_EN
            hold_cnt_q <= 4'd1;
`endif
        end else begin
            // No requests: go idle; sel keeps its last granted value.
            state_q    <= IDLE;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule : mux_sel_arbiter8

// File: tb/tb_mux_sel_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter8
// Self-checking bench: a behavioural model (holder index, burst length and a
// priority list rebuilt every cycle) runs alongside the DUT and is compared
// on every cycle; directed steps add literal expectations.
// Honours ARB_HOLD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter8;

    localparam int MH = 4;

`ifdef ARB_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state
    int m_holder = -1;   // -1 when nothing granted
    int m_sel    = 0;
    int m_ptr    = 0;
    int m_burst  = 0;

    mux_sel_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req),
        .gnt_o   (gnt),
        .sel_o   (sel),
        .valid_o (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: winner is the first requester in priority order
    // ptr, ptr+1, ..., ptr+7 (mod 8).
    always @(posedge clk) begin
        int order [8];
        int w;
        bit stay;
        if (reset) begin
            m_holder = -1; m_sel = 0; m_ptr = 0; m_burst = 0;
        end else begin
            stay = HOLD && (m_holder >= 0) && req[m_holder] && (m_burst < MH);
            if (stay) begin
                m_burst++;
            end else begin
                for (int k = 0; k < 8; k++) order[k] = (m_ptr + k) % 8;
                w = -1;
                foreach (order[k]) if (w < 0 && req[order[k]]) w = order[k];
                if (w >= 0) begin
                    m_holder = w; m_sel = w; m_ptr = (w + 1) % 8; m_burst = 1;
                end else begin
                    m_holder = -1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt",   int'(gnt),   (m_holder >= 0) ? (1 << m_holder) : 0);
            chk("model_sel",   int'(sel),   m_sel);
            chk("model_valid", int'(valid), (m_holder >= 0) ? 1 : 0);
        end
    end

    task automatic step(input logic [7:0] r, input logic rs);
        @(negedge clk);
        req   = r;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = 8'h00;
        reset = 1'b1;

        // Reset with all requesting for 2 cycles
        step(8'hFF, 1'b1);
        chk_en = 1'b1;
        step(8'hFF, 1'b1);
        chk("rst_gnt", int'(gnt), 8'h00);
        chk("rst_sel", int'(sel), 0);
        chk("rst_valid", int'(valid), 0);
        step(8'hFF, 1'b0);
        chk("first_gnt", int'(gnt), 8'h01);
        chk("first_sel", int'(sel), 0);

`ifndef ARB_HOLD_EN
        // Rotation: 0 already granted; next eight continue 1..7,0
        for (int i = 1; i < 9; i++) begin
            step(8'hFF, 1'b0);
            chk("rot_sel", int'(sel), i % 8);
            chk("rot_gnt", int'(gnt), 1 << (i % 8));
        end
`endif

        // Single requester
        step(8'h00, 1'b0);
        step(8'h04, 1'b0);
        chk("single_gnt", int'(gnt), 8'h04);
        chk("single_sel", int'(sel), 2);
        chk("single_valid", int'(valid), 1);
        step(8'h04, 1'b0);
        chk("single_regrant", int'(gnt), 8'h04);
        step(8'h00, 1'b0);
        chk("drop_gnt", int'(gnt), 8'h00);
        chk("drop_valid", int'(valid), 0);
        chk("drop_sel_kept", int'(sel), 2);

`ifdef ARB_HOLD_EN
        // Burst limit with two steady requesters
        step(8'h03, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(8'h03, 1'b0);
            chk("hold_sel", int'(sel), (i < 4 || i == 8) ? 0 : 1);
        end
`endif

        // Early-release handoff 0 -> 5 with no bubble
        step(8'h21, 1'b1);
        step(8'h21, 1'b0);
        chk("handoff_pre_sel", int'(sel), 0);
        step(8'h20, 1'b0);
        chk("handoff_sel", int'(sel), 5);
        chk("handoff_gnt", int'(gnt), 8'h20);
        chk("handoff_valid", int'(valid), 1);

        // Reset mid-grant
        step(8'hFF, 1'b1);
        chk("midrst_gnt", int'(gnt), 8'h00);
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_valid", int'(valid), 0);
        step(8'hFF, 1'b0);
        chk("midrst_after_sel", int'(sel), 0);
        chk("midrst_after_gnt", int'(gnt), 8'h01);

        // Randomized traffic of varying density, occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            case ($urandom_range(0, 3))
                0: r = 8'($urandom);
                1: r = 8'($urandom) & 8'($urandom);
                2: r = 8'(1) << $urandom_range(0, 7);
                default: r = 8'($urandom) | 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            step(r, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_sel_arbiter8

// File: doc/mux_sel_arbiter8.md
# mux_sel_arbiter8

Round-robin arbiter that shares one 8:1 selection datapath among eight requesters in the victim-cache design. It picks one requester per arbitration, drives the registered 3-bit select to the 8:1 mux, and returns a one-hot grant to the winner. Fairness comes from a rotating priority pointer. An optional hold mode lets a winner keep the mux for a bounded burst.

## Interface
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold a grant in hold mode; legal range 1..15. Ignored when hold mode is compiled out.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] high means requester i wants the mux.
- gnt  output  8  one-hot grant, registered; all zeros when nothing is granted.
- sel  output  3  registered mux select; equals the index of the set bit of gnt while valid=1.
- valid  output  1  registered; high when gnt is non-zero.

## Operation
- State: ptr[2:0] (highest-priority index), state {IDLE, GRANT}, hold_cnt[3:0], plus the gnt/sel/valid registers.
- Arbitration is combinational each cycle. The winner is the first i with req[i]=1, scanning ptr, ptr+1, …, ptr+7, with indices taken mod 8.
- IDLE:
  - If any req bit is high: register gnt/sel/valid for the winner, set ptr = winner+1 (mod 8), set hold_cnt=1, go to GRANT.
  - Otherwise: gnt=0, valid=0, stay in IDLE.
- GRANT, continue case: the holder's req is still high and hold_cnt < MAX_HOLD (hold mode only). Keep gnt/sel, increment hold_cnt, leave ptr unchanged.
- GRANT, re-arbitrate case: any other situation. Run the scan from the current ptr.
  - A winner exists: grant it next cycle with no idle bubble, update ptr, set hold_cnt=1.
  - No requests: go to IDLE with gnt=0 and valid=0.
  - The holder may win again only if no other requester is active.
- When valid=0, sel keeps its last granted value.
- Simultaneous events:
  - A new req rising in the same cycle the holder drops is handled by the same re-arbitration.
  - Request bits never change ptr except through a grant.

## Timing
- Reset values: gnt=8'h00, sel=3'd0, valid=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset takes effect at the first rising edge where it is sampled high, and overrides any grant in progress. The first arbitration is evaluated on the first edge after reset deasserts.
- Latency: req sampled at edge N gives gnt/sel/valid at edge N+1.
- Release: the holder's req low at edge N gives the next grant, or idle, at edge N+1.
- Back-to-back grants to different requesters need no dead cycle.
- Wrap-around: winner 7 sets ptr=0.
- Hold mode with MAX_HOLD=1 behaves identically to hold compiled out.

## Configuration
- Macro: ARB_HOLD_EN.
- Defined: a grant persists while the holder's req stays high, up to MAX_HOLD cycles, then is forced to rotate.
- Undefined: every grant lasts exactly one cycle and re-arbitration runs every cycle. hold_cnt and the MAX_HOLD comparison are removed.

## Structure
- Package arb_pkg holds:
  - NUM_REQ=8 and SEL_W=3.
  - typedef logic [SEL_W-1:0] sel_t.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick8: purely combinational rotating priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, win_idx[2:0].
  - Instantiated once.
- The top level owns all registers and the FSM.

## Test plan
- Reset: hold reset high for 2 cycles with req=8'hFF. Require gnt=8'h00, sel=0, valid=0. Release reset; on the next edge require gnt=8'h01, sel=0.
- Single requester: req=8'b0000_0100 at edge N. Require gnt=8'h04, sel=2, valid=1 at N+1. Drop req at edge M. Require gnt=0, valid=0 at M+1, with sel still 2.
- Rotation with hold off: req=8'hFF held for 9 cycles. Require sel sequence 0,1,2,3,4,5,6,7,0, with gnt tracking one-hot.
- Hold on, MAX_HOLD=4: req=8'h03 steady. Require sel=0 for 4 cycles, then 1 for 4, then 0 again.
- Early-release handoff, hold on: sel=0 granted with req=8'h21. Drop req[0]. Require sel=5, gnt=8'h20 on the next edge with valid never low.
- Reset mid-grant: while sel=5 and valid=1, pulse reset for 1 cycle with req=8'hFF. Require outputs zero during reset, then first grant sel=0 because ptr was reset.
